// File: rtl/yin_diff_engine.sv
// YIN difference-function engine: for each tau in [tau_min, tau_max] it streams sample pairs from memory and accumulates d(tau).
// Optional running-minimum tracker is enabled by defining YIN_DIFF_MIN_TRACK_EN.
module yin_diff_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int WINDOW_BITS = 8,
    parameter int TAU_BITS    = 6,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 1,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+WINDOW_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [TAU_BITS-1:0]   tau_min_i,
    input  logic [TAU_BITS-1:0]   tau_max_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_en_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [TAU_BITS-1:0]   res_tau_o,
    output logic [ACC_WIDTH-1:0]  res_sum_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ACC_WIDTH-1:0]  min_sum_o,
    output logic [TAU_BITS-1:0]   min_tau_o
);

    localparam int WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_XJ, S_WAIT_XJ, S_FETCH_XT, S_WAIT_XT, S_ACCUM, S_EMIT, S_FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [WINDOW_BITS-1:0]  j_q, j_d;
    logic [TAU_BITS-1:0]     tau_q, tau_d;
    logic [TAU_BITS-1:0]     tau_max_q, tau_max_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   xj_q, xj_d;
    logic [DATA_WIDTH-1:0]   xt_q, xt_d;
    logic [WCW-1:0]          wcnt_q, wcnt_d;

    logic                    fetch_s;
    logic [ADDR_WIDTH-1:0]   addr_s;

    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    mem_rd_en_q;
    logic                    res_valid_q;
    logic [TAU_BITS-1:0]     res_tau_q;
    logic [ACC_WIDTH-1:0]    res_sum_q;
    logic                    busy_q;
    logic                    done_q;

    function automatic logic [ACC_WIDTH-1:0] sq_diff(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0]   d;
        logic [2*DATA_WIDTH-1:0] p;
        d = (a >= b) ? (a - b) : (b - a);
        p = {{DATA_WIDTH{1'b0}}, d} * {{DATA_WIDTH{1'b0}}, d};
        return ACC_WIDTH'(p);
    endfunction

    // FSM and datapath state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            j_q       <= {WINDOW_BITS{1'b0}};
            tau_q     <= {TAU_BITS{1'b0}};
            tau_max_q <= {TAU_BITS{1'b0}};
            base_q    <= {ADDR_WIDTH{1'b0}};
            acc_q     <= {ACC_WIDTH{1'b0}};
            xj_q      <= {DATA_WIDTH{1'b0}};
            xt_q      <= {DATA_WIDTH{1'b0}};
            wcnt_q    <= {WCW{1'b0}};
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            tau_q     <= tau_d;
            tau_max_q <= tau_max_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            xj_q      <= xj_d;
            xt_q      <= xt_d;
            wcnt_q    <= wcnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        tau_d     = tau_q;
        tau_max_d = tau_max_q;
        base_d    = base_q;
        acc_d     = acc_q;
        xj_d      = xj_q;
        xt_d      = xt_q;
        wcnt_d    = {WCW{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d    = base_addr_i;
                    tau_d     = tau_min_i;
                    tau_max_d = tau_max_i;
                    j_d       = {WINDOW_BITS{1'b0}};
                    acc_d     = {ACC_WIDTH{1'b0}};
                    state_d   = (tau_min_i > tau_max_i) ? S_FIN : S_FETCH_XJ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH_XJ: state_d = S_WAIT_XJ;
            S_WAIT_XJ: begin
                // Capture lands on the last wait cycle, exactly MEM_LATENCY after the strobe
                if (wcnt_q == WAIT_LAST) begin
                    xj_d    = mem_rd_data_i;
                    state_d = S_FETCH_XT;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_FETCH_XT: state_d = S_WAIT_XT;
            S_WAIT_XT: begin
                if (wcnt_q == WAIT_LAST) begin
                    xt_d    = mem_rd_data_i;
                    state_d = S_ACCUM;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + sq_diff(xj_q, xt_q);
                if (j_q == {WINDOW_BITS{1'b1}}) begin
                    state_d = S_EMIT;
                end else begin
                    j_d     = j_q + WINDOW_BITS'(1);
                    state_d = S_FETCH_XJ;
                end
            end
            S_EMIT: begin
                if (res_ready_i) begin
                    if (tau_q == tau_max_q) begin
                        state_d = S_FIN;
                    end else begin
                        tau_d   = tau_q + TAU_BITS'(1);
                        j_d     = {WINDOW_BITS{1'b0}};
                        acc_d   = {ACC_WIDTH{1'b0}};
                        state_d = S_FETCH_XJ;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign fetch_s = (state_d == S_FETCH_XJ) || (state_d == S_FETCH_XT);
    assign addr_s  = base_d + ADDR_WIDTH'(j_d)
                   + ((state_d == S_FETCH_XT) ? ADDR_WIDTH'(tau_d) : {ADDR_WIDTH{1'b0}});

    // Registered outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_rd_en_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_tau_q   <= {TAU_BITS{1'b0}};
            res_sum_q   <= {ACC_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_rd_en_q <= fetch_s;
            if (fetch_s) begin
                mem_addr_q <= addr_s;
            end
            res_valid_q <= (state_d == S_EMIT);
            if ((state_q == S_ACCUM) && (state_d == S_EMIT)) begin
                res_tau_q <= tau_q;
                res_sum_q <= acc_d;
            end
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_d == S_FIN);
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign res_valid_o = res_valid_q;
    assign res_tau_o   = res_tau_q;
    assign res_sum_o   = res_sum_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

`ifdef YIN_DIFF_MIN_TRACK_EN
    logic [ACC_WIDTH-1:0] min_sum_q;
    logic [TAU_BITS-1:0]  min_tau_q;

    // Running minimum over transferred results; strict compare keeps the first minimum
    always_ff @(posedge clk) begin
        if (reset) begin
            min_sum_q <= {ACC_WIDTH{1'b1}};
            min_tau_q <= {TAU_BITS{1'b0}};
        end else if ((state_q == S_IDLE) && start_i) begin
            min_sum_q <= {ACC_WIDTH{1'b1}};
            min_tau_q <= {TAU_BITS{1'b0}};
        end else if ((state_q == S_EMIT) && res_ready_i && (res_sum_q < min_sum_q)) begin
            min_sum_q <= res_sum_q;
            min_tau_q <= res_tau_q;
        end else begin
            min_sum_q <= min_sum_q;
            min_tau_q <= min_tau_q;
        end
    end

    assign min_sum_o = min_sum_q;
    assign min_tau_o = min_tau_q;
`else
    assign min_sum_o = {ACC_WIDTH{1'b0}};
    assign min_tau_o = {TAU_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_yin_diff_engine.sv
// Randomised bench for yin_diff_engine: two instances (read latency 1 and 3) checked against a sum-of-squares reference model.
module tb_yin_diff_engine;

    localparam int DW    = 16;
    localparam int WB    = 4;
    localparam int TB    = 6;
    localparam int AW    = 8;
    localparam int ACC   = 2*DW+WB;
    localparam int N     = 1 << WB;
    localparam int MEMSZ = 1 << AW;

    typedef struct packed { logic [AW-1:0] addr; logic [7:0] gap; } rd_t;
    typedef struct packed { logic [TB-1:0] tau; logic [ACC-1:0] sum; } res_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [TB-1:0] tau_min, tau_max;
    logic          res_ready;

    logic [AW-1:0]  mem_addr  [2];
    logic           mem_rd_en [2];
    logic [DW-1:0]  rd_data   [2];
    logic           res_valid [2];
    logic [TB-1:0]  res_tau   [2];
    logic [ACC-1:0] res_sum   [2];
    logic           busy      [2];
    logic           done      [2];
    logic [ACC-1:0] min_sum   [2];
    logic [TB-1:0]  min_tau   [2];

    logic [DW-1:0] mem [MEMSZ];

    rd_t  exp_rd  [2][$];
    res_t exp_res [2][$];
    logic [ACC-1:0] exp_min_sum;
    logic [TB-1:0]  exp_min_tau;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt [2];
    int rd_count [2];
    int last_rd  [2];
    logic prev_valid [2];
    logic prev_ready [2];
    logic prev_done  [2];
    logic [TB-1:0]  prev_tau [2];
    logic [ACC-1:0] prev_sum [2];

    logic rdy_rand = 1'b0;
    logic stall_en = 1'b0;
    int   stall_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] pipe [3];

        yin_diff_engine #(
            .DATA_WIDTH(DW), .WINDOW_BITS(WB), .TAU_BITS(TB),
            .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .ACC_WIDTH(ACC)
        ) u_dut (
            .clk(clk), .reset(reset), .start_i(start), .base_addr_i(base_addr),
            .tau_min_i(tau_min), .tau_max_i(tau_max),
            .mem_addr_o(mem_addr[g]), .mem_rd_en_o(mem_rd_en[g]), .mem_rd_data_i(rd_data[g]),
            .res_valid_o(res_valid[g]), .res_ready_i(res_ready),
            .res_tau_o(res_tau[g]), .res_sum_o(res_sum[g]),
            .busy_o(busy[g]), .done_o(done[g]),
            .min_sum_o(min_sum[g]), .min_tau_o(min_tau[g])
        );

        // Memory with LAT-cycle read latency; junk on the bus whenever no read is in flight
        always @(posedge clk) begin
            pipe[0] <= mem_rd_en[g] ? mem[mem_addr[g]] : DW'($urandom);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign rd_data[g] = pipe[LAT-1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint model_d(input int base, input int tau);
        longint s = 0;
        int a, b, d;
        for (int j = 0; j < N; j++) begin
            a = int'(mem[(base + j) % MEMSZ]);
            b = int'(mem[(base + j + tau) % MEMSZ]);
            d = (a > b) ? (a - b) : (b - a);
            s += longint'(d) * longint'(d);
        end
        return s;
    endfunction

    task automatic prepare(input int base, input int tmin, input int tmax);
        longint best;
        longint s;
        exp_min_sum = {ACC{1'b1}};
        exp_min_tau = '0;
        best = -1;
        for (int g = 0; g < 2; g++) begin
            exp_rd[g].delete();
            exp_res[g].delete();
        end
        for (int t = tmin; t <= tmax; t++) begin
            s = model_d(base, t);
            if (best < 0 || s < best) begin
                best = s;
                exp_min_sum = ACC'(s);
                exp_min_tau = TB'(t);
            end
            for (int g = 0; g < 2; g++) begin
                int lat = (g == 0) ? 1 : 3;
                for (int j = 0; j < N; j++) begin
                    exp_rd[g].push_back({AW'(base + j), 8'((j == 0) ? 0 : lat + 2)});
                    exp_rd[g].push_back({AW'(base + j + t), 8'(lat + 1)});
                end
                exp_res[g].push_back({TB'(t), ACC'(s)});
            end
        end
    endtask

    task automatic chk_reset_vals();
        for (int g = 0; g < 2; g++) begin
            check("rst_mem_addr", 64'(mem_addr[g]), 64'd0);
            check("rst_rd_en", 64'(mem_rd_en[g]), 64'd0);
            check("rst_res_valid", 64'(res_valid[g]), 64'd0);
            check("rst_res_tau", 64'(res_tau[g]), 64'd0);
            check("rst_res_sum", 64'(res_sum[g]), 64'd0);
            check("rst_busy", 64'(busy[g]), 64'd0);
            check("rst_done", 64'(done[g]), 64'd0);
`ifdef YIN_DIFF_MIN_TRACK_EN
            check("rst_min_sum", 64'(min_sum[g]), 64'({ACC{1'b1}}));
`else
            check("rst_min_sum", 64'(min_sum[g]), 64'd0);
`endif
            check("rst_min_tau", 64'(min_tau[g]), 64'd0);
        end
    endtask

    task automatic pulse_start(input int base, input int tmin, input int tmax);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); tau_min = TB'(tmin); tau_max = TB'(tmax);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input int base, input int tmin, input int tmax, input bit poke);
        int d0, d1;
        bit fin;
        prepare(base, tmin, tmax);
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        pulse_start(base, tmin, tmax);
        if (tmin > tmax) begin
            check("empty_done_next_cycle_l1", 64'(done[0]), 64'd1);
            check("empty_done_next_cycle_l3", 64'(done[1]), 64'd1);
        end
        fin = 1'b0;
        for (int c = 0; c < 30000 && !fin; c++) begin
            @(posedge clk); #1;
            if (poke && c == 50) begin
                start = 1'b1; base_addr = AW'($urandom); tau_min = '0; tau_max = '1;
            end else begin
                start = 1'b0;
            end
            fin = (done_cnt[0] > d0) && (done_cnt[1] > d1);
        end
        start = 1'b0;
        check("run_finished", 64'(fin), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("results_left", 64'(exp_res[g].size()), 64'd0);
            check("reads_left", 64'(exp_rd[g].size()), 64'd0);
        end
        check("done_pulses_l1", 64'(done_cnt[0] - d0), 64'd1);
        check("done_pulses_l3", 64'(done_cnt[1] - d1), 64'd1);
    endtask

    // Single compare process: read addresses/spacing, results, stall stability, done and minimum
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                prev_valid[g] = 1'b0;
                prev_ready[g] = 1'b0;
                prev_done[g]  = 1'b0;
            end else begin
                if (mem_rd_en[g]) begin
                    rd_t e;
                    rd_count[g]++;
                    check("rd_while_busy", 64'(busy[g]), 64'd1);
                    check("rd_expected", 64'(exp_rd[g].size() != 0), 64'd1);
                    if (exp_rd[g].size() != 0) begin
                        e = exp_rd[g].pop_front();
                        check("rd_addr", 64'(mem_addr[g]), 64'(e.addr));
                        if (e.gap != 8'd0) check("rd_spacing", 64'(cyc - last_rd[g]), 64'(e.gap));
                    end
                    last_rd[g] = cyc;
                end
                if (res_valid[g]) begin
                    check("no_read_in_emit", 64'(mem_rd_en[g]), 64'd0);
                    check("valid_busy", 64'(busy[g]), 64'd1);
                    if (prev_valid[g] && !prev_ready[g]) begin
                        check("stall_tau_stable", 64'(res_tau[g]), 64'(prev_tau[g]));
                        check("stall_sum_stable", 64'(res_sum[g]), 64'(prev_sum[g]));
                    end
                    if (res_ready) begin
                        res_t r;
                        check("res_expected", 64'(exp_res[g].size() != 0), 64'd1);
                        if (exp_res[g].size() != 0) begin
                            r = exp_res[g].pop_front();
                            check("res_tau", 64'(res_tau[g]), 64'(r.tau));
                            check("res_sum", 64'(res_sum[g]), 64'(r.sum));
                        end
                    end
                end else if (prev_valid[g] && !prev_ready[g]) begin
                    check("valid_dropped_in_stall", 64'(res_valid[g]), 64'd1);
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    check("done_one_cycle", 64'(prev_done[g]), 64'd0);
                    check("done_busy", 64'(busy[g]), 64'd1);
                    check("done_all_results", 64'(exp_res[g].size()), 64'd0);
                    check("done_all_reads", 64'(exp_rd[g].size()), 64'd0);
`ifdef YIN_DIFF_MIN_TRACK_EN
                    check("min_sum", 64'(min_sum[g]), 64'(exp_min_sum));
                    check("min_tau", 64'(min_tau[g]), 64'(exp_min_tau));
`else
                    check("min_sum_off", 64'(min_sum[g]), 64'd0);
                    check("min_tau_off", 64'(min_tau[g]), 64'd0);
`endif
                end
                if (prev_done[g]) check("idle_after_done", 64'(busy[g]), 64'd0);
                prev_valid[g] = res_valid[g];
                prev_ready[g] = res_ready;
                prev_done[g]  = done[g];
                prev_tau[g]   = res_tau[g];
                prev_sum[g]   = res_sum[g];
            end
        end
    end

    // Result-ready driver: always-ready, random back-pressure, or a 10-cycle stall at tau=2
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!stall_en) stall_cnt = 0;
            if (stall_en && res_valid[0] && res_tau[0] == TB'(2) && stall_cnt < 10) begin
                res_ready = 1'b0;
                stall_cnt++;
            end else if (rdy_rand) begin
                res_ready = ($urandom_range(0, 3) != 0);
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    initial begin
        int d0, d1;
        bit hit;
        for (int g = 0; g < 2; g++) begin
            done_cnt[g] = 0; rd_count[g] = 0; last_rd[g] = 0;
        end
        reset = 1'b1; start = 1'b0; base_addr = '0; tau_min = '0; tau_max = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 1'b0;

        for (int i = 0; i < MEMSZ; i++) mem[i] = 16'h1234;
        check("model_const", 64'(model_d(0, 3)), 64'd0);
        run(0, 0, 5, 1'b0);

        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'(i);
        check("model_ramp_t1", 64'(model_d(0, 1)), 64'd16);
        check("model_ramp_t2", 64'(model_d(0, 2)), 64'd64);
        check("model_ramp_t3", 64'(model_d(0, 3)), 64'd144);
        check("model_ramp_t4", 64'(model_d(0, 4)), 64'd256);
        run(0, 1, 4, 1'b0);

        stall_en = 1'b1;
        run(0, 1, 4, 1'b0);
        check("stall_cycles", 64'(stall_cnt), 64'd10);
        stall_en = 1'b0;

        d0 = rd_count[0];
        run(0, 7, 3, 1'b0);
        check("empty_no_reads", 64'(rd_count[0] - d0), 64'd0);

        prepare(0, 1, 4);
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        pulse_start(0, 1, 4);
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(posedge clk);
            hit = (rd_count[0] - rd_count[1] >= 0) && (exp_rd[0].size() <= 4*N*2 - 44);
        end
        check("reached_tau2_j5", 64'(hit), 64'd1);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals();
        for (int g = 0; g < 2; g++) begin
            exp_rd[g].delete();
            exp_res[g].delete();
        end
        reset = 1'b0;
        check("reset_no_done_l1", 64'(done_cnt[0] - d0), 64'd0);
        check("reset_no_done_l3", 64'(done_cnt[1] - d1), 64'd0);
        run(0, 1, 4, 1'b0);

        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'((i % 3) * 100);
        check("model_p3_t1", 64'(model_d(0, 1)), 64'd310000);
        check("model_p3_t2", 64'(model_d(0, 2)), 64'd340000);
        prepare(0, 1, 5);
        check("model_p3_min_tau", 64'(exp_min_tau), 64'd3);
        check("model_p3_min_sum", 64'(exp_min_sum), 64'd0);
        run(0, 1, 5, 1'b0);

        rdy_rand = 1'b1;
        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'($urandom);
        run(250, 60, 63, 1'b1);
        for (int it = 0; it < 6; it++) begin
            int b, lo, hi;
            for (int i = 0; i < MEMSZ; i++) mem[i] = (it % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 15));
            b  = int'($urandom_range(0, MEMSZ - 1));
            lo = int'($urandom_range(0, (1 << TB) - 1));
            hi = (it == 3) ? lo - 1 : lo + int'($urandom_range(0, 4));
            if (hi > (1 << TB) - 1) hi = (1 << TB) - 1;
            if (hi < 0) hi = lo + 1;
            run(b, lo, hi, it == 1);
        end
        rdy_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/yin_diff_engine.md
YIN_DIFF_ENGINE -- requirements
Module: yin_diff_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width; samples are unsigned.
REQ-002 Parameter WINDOW_BITS, default 8: the window holds N = 2^WINDOW_BITS sample pairs per tau.
REQ-003 Parameter TAU_BITS, default 6: tau range is 0..2^TAU_BITS-1.
REQ-004 Parameter ADDR_WIDTH, default 16: sample memory address width.
REQ-005 Parameter MEM_LATENCY, default 1 (minimum 1): cycles from mem_rd_en to valid mem_rd_data.
REQ-006 Parameter ACC_WIDTH, default 2*DATA_WIDTH+WINDOW_BITS: result width.
REQ-007 clk  input  1  clock; all logic is on the rising edge.
REQ-008 reset  input  1  reset, synchronous, active-high.
REQ-009 start  input  1  one-cycle pulse that launches a run; ignored while busy=1.
REQ-010 base_addr  input  ADDR_WIDTH  address of x[0]; sampled on accepted start.
REQ-011 tau_min, tau_max  input  TAU_BITS each  inclusive tau range; sampled on accepted start.
REQ-012 mem_addr  output  ADDR_WIDTH  sample read address.
REQ-013 mem_rd_en  output  1  read strobe.
REQ-014 mem_rd_data  input  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_rd_en.
REQ-015 res_valid / res_ready  output / input  1 each  result handshake.
REQ-016 res_tau / res_sum  output  TAU_BITS / ACC_WIDTH  result tau and d(tau).
REQ-017 busy / done  output  1 each  run in progress / one-cycle end-of-run pulse.
REQ-018 min_sum / min_tau  output  ACC_WIDTH / TAU_BITS  running minimum (see Configuration).

Function
REQ-019 For each tau from tau_min to tau_max, the block SHALL compute d(tau) = sum over j=0..N-1 of (x[base+j] - x[base+j+tau])^2, using the exact absolute difference and no truncation before ACC_WIDTH.
REQ-020 FSM states: IDLE -> FETCH_XJ -> WAIT_XJ -> FETCH_XT -> WAIT_XT -> ACCUM, looping to FETCH_XJ for the next j; after j=N-1, ACCUM goes to EMIT, then FETCH_XJ for the next tau, or FIN after tau_max; FIN goes to IDLE.
REQ-021 Each FETCH state SHALL assert mem_rd_en for exactly one cycle with mem_addr = (base+j) or (base+j+tau), modulo 2^ADDR_WIDTH; at all other times mem_rd_en=0.
REQ-022 Data SHALL be captured exactly MEM_LATENCY cycles after the strobe; each pair SHALL take 2*MEM_LATENCY+3 cycles.
REQ-023 The accumulator SHALL clear at the start of each tau.
REQ-024 EMIT SHALL hold res_valid=1 with stable res_tau/res_sum until the cycle res_ready=1; the transfer completes in that cycle, and no memory reads occur while stalled.
REQ-025 done SHALL pulse for one cycle in FIN; busy=1 in every state except IDLE.
REQ-026 If tau_min > tau_max on an accepted start, the block SHALL issue no reads and emit no results, and done SHALL pulse on the cycle after start.
REQ-027 A start coincident with done is ignored; a new start is accepted from IDLE only.

Reset
REQ-028 reset SHALL override all other inputs, returning the FSM to IDLE at the next edge even mid-run, with no result emitted and no done pulse.
REQ-029 Reset values: mem_addr=0, mem_rd_en=0, res_valid=0, res_tau=0, res_sum=0, busy=0, done=0, min_sum=all-ones, min_tau=0.

Configuration
REQ-030 Macro YIN_DIFF_MIN_TRACK_EN.
- Defined: on accepted start, min_sum is set to all-ones and min_tau to 0.
- On each completed result transfer with res_sum < min_sum (strict, so the first minimum wins), both are updated.
- Final values are valid when done pulses and hold until the next start.
REQ-031 Undefined: min_sum and min_tau SHALL be constant 0 and no comparator logic is generated.

Verification (WINDOW_BITS=4, MEM_LATENCY=1 unless stated)
REQ-032 Constant memory 0x1234, tau 0..5, res_ready=1 -> six results, all res_sum=0, res_tau=0..5 in order, then a single done pulse.
REQ-033 Ramp x[n]=n, base=0, tau 1..4 -> res_sum = 16, 64, 144, 256; each pair takes exactly 5 cycles between mem_rd_en pulses of the same kind.
REQ-034 Ramp with res_ready held low for 10 cycles at tau=2 -> res_valid, res_tau and res_sum stay stable, no mem_rd_en toggles, and the remaining results are unchanged.
REQ-035 tau_min=7, tau_max=3 -> zero reads and zero results; done pulses 1 cycle after start.
REQ-036 reset asserted mid-run at tau=2, j=5 -> all outputs at their reset values next cycle; a following start yields a correct full run.
REQ-037 MIN_TRACK_EN defined, memory with period 3 (0, 100, 200, repeat), tau 1..5 -> min_tau=3, min_sum=0 at done; MEM_LATENCY=3 gives identical results.
